// File: rtl/hpu_pkg.sv
// Shared definitions for the L2 allocation-stage blocks.
//   waysel_state_e : way-select FSM states
//   L2_WAY_WTH     : default way-number width
//   L2_WAY_NUM     : default number of ways
//   l2_way_t       : way number at the default width
package hpu_pkg;

  localparam int unsigned L2_WAY_WTH = 2;
  localparam int unsigned L2_WAY_NUM = 1 << L2_WAY_WTH;

  typedef logic [L2_WAY_WTH-1:0] l2_way_t;

  typedef enum logic [1:0] {
    IDLE,
    DECIDE,
    WB,
    RESP
  } waysel_state_e;

endpackage

// File: rtl/l2_way_penc.sv
// Lowest-index priority encoder.
//   vec_i : request vector, bit 0 has highest priority
//   idx_o : index of the lowest set bit (0 when none set)
//   any_o : at least one bit of vec_i is set
module l2_way_penc
  import hpu_pkg::*;
#(
  parameter  int unsigned IDX_WTH = L2_WAY_WTH,
  localparam int unsigned VEC_WTH = 1 << IDX_WTH
) (
  input  logic [VEC_WTH-1:0] vec_i,
  output logic [IDX_WTH-1:0] idx_o,
  output logic               any_o
);

  logic found;

  always_comb begin
    idx_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < VEC_WTH; i++) begin
      if (vec_i[i] && !found) begin
        idx_o = IDX_WTH'(i);
        found = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/l2_way_select.sv
// L2 allocation stage: picks the target way for a lookup (hit way, first
// invalid way, or pseudo-LRU victim), requests a writeback for a dirty
// victim, returns the decision and pulses the LRU update once per request.
//   clk_i / rst_i          : clock, asynchronous active-low reset
//   req_*                  : lookup request (index + hit/valid/dirty vectors)
//   lru_rindex_o / lru_vtm_way_i : LRU victim lookup (same-cycle reply)
//   lru_update_o / lru_windex_o / lru_cur_way_o : LRU update strobe
//   wb_req_o / wb_index_o / wb_way_o / wb_ack_i : dirty-victim writeback
//   rsp_*                  : decision (hit flag, way, index)
// Optional: define L2_WAYSEL_MHIT_CHK_EN to add the sticky multi-hit flag
// err_mhit_o and a one-hot-or-zero check on the hit vector.
module l2_way_select
  import hpu_pkg::*;
#(
  parameter  int unsigned INDEX_WTH = 3,
  parameter  int unsigned WAY_WTH   = L2_WAY_WTH,
  localparam int unsigned WAY_NUM   = 1 << WAY_WTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_vld_i,
  output logic                 req_rdy_o,
  input  logic [INDEX_WTH-1:0] req_index_i,
  input  logic [WAY_NUM-1:0]   way_hit_i,
  input  logic [WAY_NUM-1:0]   way_vld_i,
  input  logic [WAY_NUM-1:0]   way_dirty_i,
  output logic [INDEX_WTH-1:0] lru_rindex_o,
  input  logic [WAY_WTH-1:0]   lru_vtm_way_i,
  output logic                 lru_update_o,
  output logic [INDEX_WTH-1:0] lru_windex_o,
  output logic [WAY_WTH-1:0]   lru_cur_way_o,
  output logic                 wb_req_o,
  output logic [INDEX_WTH-1:0] wb_index_o,
  output logic [WAY_WTH-1:0]   wb_way_o,
  input  logic                 wb_ack_i,
  output logic                 rsp_vld_o,
  input  logic                 rsp_rdy_i,
  output logic                 rsp_hit_o,
  output logic [WAY_WTH-1:0]   rsp_way_o,
`ifdef L2_WAYSEL_MHIT_CHK_EN
  output logic                 err_mhit_o,
`endif
  output logic [INDEX_WTH-1:0] rsp_index_o
);

  waysel_state_e state_q, state_d;

  logic [INDEX_WTH-1:0] index_q;
  logic [WAY_NUM-1:0]   hit_q, vld_q, dirty_q;
  logic [WAY_WTH-1:0]   way_q, way_d;
  logic                 sel_hit_q, sel_hit_d;
  logic                 upd_q;

  logic [WAY_WTH-1:0]   hit_idx, inv_idx;
  logic                 hit_any, inv_any;
  logic                 vtm_dirty;

  l2_way_penc #(.IDX_WTH(WAY_WTH)) u_hit_penc (
    .vec_i (hit_q),
    .idx_o (hit_idx),
    .any_o (hit_any)
  );

  l2_way_penc #(.IDX_WTH(WAY_WTH)) u_inv_penc (
    .vec_i (~vld_q),
    .idx_o (inv_idx),
    .any_o (inv_any)
  );

  // Way selection; a writeback is only needed when allocating over a line
  // that is both valid and dirty.
  always_comb begin
    way_d     = lru_vtm_way_i;
    sel_hit_d = 1'b0;
    if (hit_any) begin
      way_d     = hit_idx;
      sel_hit_d = 1'b1;
    end else if (inv_any) begin
      way_d = inv_idx;
    end
    vtm_dirty = !hit_any && vld_q[way_d] && dirty_q[way_d];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_vld_i) state_d = DECIDE;
      DECIDE:  state_d = vtm_dirty ? WB : RESP;
      WB:      if (wb_ack_i)  state_d = RESP;
      RESP:    if (rsp_rdy_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_rdy_o     = (state_q == IDLE);
    wb_req_o      = (state_q == WB);
    rsp_vld_o     = (state_q == RESP);
    lru_rindex_o  = index_q;
    lru_update_o  = upd_q;
    lru_windex_o  = index_q;
    lru_cur_way_o = way_q;
    wb_index_o    = index_q;
    wb_way_o      = way_q;
    rsp_hit_o     = sel_hit_q;
    rsp_way_o     = way_q;
    rsp_index_o   = index_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      index_q   <= '0;
      hit_q     <= '0;
      vld_q     <= '0;
      dirty_q   <= '0;
      way_q     <= '0;
      sel_hit_q <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      if (state_q == IDLE && req_vld_i) begin
        index_q <= req_index_i;
        hit_q   <= way_hit_i;
        vld_q   <= way_vld_i;
        dirty_q <= way_dirty_i;
      end
      if (state_q == DECIDE) begin
        way_q     <= way_d;
        sel_hit_q <= sel_hit_d;
      end
      // Registered so the strobe lands exactly on the first RESP cycle.
      upd_q <= (state_q != RESP) && (state_d == RESP);
    end
  end

`ifdef L2_WAYSEL_MHIT_CHK_EN
  logic err_mhit_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_mhit_q <= 1'b0;
    end else if (state_q == DECIDE && ((hit_q & (hit_q - WAY_NUM'(1))) != '0)) begin
      err_mhit_q <= 1'b1;
    end
  end

  assign err_mhit_o = err_mhit_q;

  a_hit_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_i)
    (state_q == DECIDE) |-> $onehot0(hit_q))
    else $warning("l2_way_select: multiple way hits at index %0d", index_q);
`endif

endmodule

// File: tb/tb_l2_way_select.sv
module tb_l2_way_select;
  import hpu_pkg::*;

  localparam int unsigned IW = 3;
  localparam int unsigned WW = 2;
  localparam int unsigned WN = 1 << WW;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_vld_i;
  logic          req_rdy_o;
  logic [IW-1:0] req_index_i;
  logic [WN-1:0] way_hit_i, way_vld_i, way_dirty_i;
  logic [IW-1:0] lru_rindex_o;
  logic [WW-1:0] lru_vtm_way_i;
  logic          lru_update_o;
  logic [IW-1:0] lru_windex_o;
  logic [WW-1:0] lru_cur_way_o;
  logic          wb_req_o;
  logic [IW-1:0] wb_index_o;
  logic [WW-1:0] wb_way_o;
  logic          wb_ack_i;
  logic          rsp_vld_o;
  logic          rsp_rdy_i;
  logic          rsp_hit_o;
  logic [WW-1:0] rsp_way_o;
  logic [IW-1:0] rsp_index_o;
`ifdef L2_WAYSEL_MHIT_CHK_EN
  logic          err_mhit_o;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk_i = ~clk_i;

  l2_way_select #(.INDEX_WTH(IW), .WAY_WTH(WW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_vld_i     (req_vld_i),
    .req_rdy_o     (req_rdy_o),
    .req_index_i   (req_index_i),
    .way_hit_i     (way_hit_i),
    .way_vld_i     (way_vld_i),
    .way_dirty_i   (way_dirty_i),
    .lru_rindex_o  (lru_rindex_o),
    .lru_vtm_way_i (lru_vtm_way_i),
    .lru_update_o  (lru_update_o),
    .lru_windex_o  (lru_windex_o),
    .lru_cur_way_o (lru_cur_way_o),
    .wb_req_o      (wb_req_o),
    .wb_index_o    (wb_index_o),
    .wb_way_o      (wb_way_o),
    .wb_ack_i      (wb_ack_i),
    .rsp_vld_o     (rsp_vld_o),
    .rsp_rdy_i     (rsp_rdy_i),
    .rsp_hit_o     (rsp_hit_o),
    .rsp_way_o     (rsp_way_o),
`ifdef L2_WAYSEL_MHIT_CHK_EN
    .err_mhit_o    (err_mhit_o),
`endif
    .rsp_index_o   (rsp_index_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One full transaction. Inputs change on negedges; outputs are checked on
  // negedges. ack_dly = cycles wb_req is expected high (ack in the last one),
  // rdy_dly = extra RESP cycles with rsp_rdy_i held low.
  task automatic run_req(input logic [IW-1:0] idx, input logic [WN-1:0] hit,
                         input logic [WN-1:0] vld, input logic [WN-1:0] dirty,
                         input logic [WW-1:0] vtm, input logic exp_hit,
                         input logic [WW-1:0] exp_way, input logic exp_wb,
                         input int unsigned ack_dly, input int unsigned rdy_dly);
    int unsigned upd_cnt;
    check("idle_rdy", req_rdy_o, 1'b1);
    req_vld_i     = 1'b1;
    req_index_i   = idx;
    way_hit_i     = hit;
    way_vld_i     = vld;
    way_dirty_i   = dirty;
    lru_vtm_way_i = vtm;
    @(negedge clk_i);
    // DECIDE: scramble the vectors, the registered copies must be used.
    req_vld_i   = 1'b0;
    req_index_i = ~idx;
    way_hit_i   = ~hit;
    way_vld_i   = ~vld;
    way_dirty_i = ~dirty;
    check("dec_rindex", lru_rindex_o, idx);
    check("dec_rdy", req_rdy_o, 1'b0);
    check("dec_rsp_vld", rsp_vld_o, 1'b0);
    check("dec_wb_req", wb_req_o, 1'b0);
    check("dec_upd", lru_update_o, 1'b0);
    @(negedge clk_i);
    if (exp_wb) begin
      for (int unsigned k = 1; k <= ack_dly; k++) begin
        check("wb_req", wb_req_o, 1'b1);
        check("wb_way", wb_way_o, exp_way);
        check("wb_index", wb_index_o, idx);
        check("wb_rsp_vld", rsp_vld_o, 1'b0);
        check("wb_upd", lru_update_o, 1'b0);
        if (k == ack_dly) wb_ack_i = 1'b1;
        @(negedge clk_i);
      end
      wb_ack_i = 1'b0;
    end
    upd_cnt = 0;
    for (int unsigned c = 0; c <= rdy_dly; c++) begin
      check("rsp_vld", rsp_vld_o, 1'b1);
      check("rsp_hit", rsp_hit_o, exp_hit);
      check("rsp_way", rsp_way_o, exp_way);
      check("rsp_index", rsp_index_o, idx);
      check("rsp_wb_req", wb_req_o, 1'b0);
      check("rsp_rdy_lo", req_rdy_o, 1'b0);
      if (c == 0) begin
        check("upd_first", lru_update_o, 1'b1);
        check("upd_windex", lru_windex_o, idx);
        check("upd_cur_way", lru_cur_way_o, exp_way);
      end
      if (lru_update_o) upd_cnt++;
      if (c == rdy_dly) rsp_rdy_i = 1'b1;
      @(negedge clk_i);
    end
    rsp_rdy_i = 1'b0;
    check("upd_count", upd_cnt, 1);
    check("post_rsp_vld", rsp_vld_o, 1'b0);
    check("post_rdy", req_rdy_o, 1'b1);
    check("post_upd", lru_update_o, 1'b0);
  endtask

  initial begin
    rst_i         = 1'b0;
    req_vld_i     = 1'b0;
    req_index_i   = '0;
    way_hit_i     = '0;
    way_vld_i     = '0;
    way_dirty_i   = '0;
    lru_vtm_way_i = '0;
    wb_ack_i      = 1'b0;
    rsp_rdy_i     = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_rdy", req_rdy_o, 1'b1);
    check("rst_rsp_vld", rsp_vld_o, 1'b0);
    check("rst_wb_req", wb_req_o, 1'b0);
    check("rst_upd", lru_update_o, 1'b0);
    check("rst_rsp_way", rsp_way_o, 0);
`ifdef L2_WAYSEL_MHIT_CHK_EN
    check("rst_mhit", err_mhit_o, 1'b0);
`endif
    rst_i = 1'b1;
    @(negedge clk_i);

    //        idx   hit      vld      dirty    vtm  hit  way  wb   ack rdy
    run_req(3'd5, 4'b0100, 4'b1111, 4'b0000, 2'd0, 1'b1, 2'd2, 1'b0, 0, 0); // hit
    run_req(3'd3, 4'b0000, 4'b1011, 4'b1011, 2'd0, 1'b0, 2'd2, 1'b0, 0, 0); // invalid fill
    run_req(3'd6, 4'b0000, 4'b1111, 4'b0000, 2'd3, 1'b0, 2'd3, 1'b0, 0, 0); // clean victim
    run_req(3'd1, 4'b0000, 4'b1111, 4'b1000, 2'd3, 1'b0, 2'd3, 1'b1, 4, 0); // dirty victim
    run_req(3'd7, 4'b0001, 4'b1111, 4'b0000, 2'd2, 1'b1, 2'd0, 1'b0, 0, 3); // backpressure
    run_req(3'd2, 4'b1000, 4'b1111, 4'b1000, 2'd1, 1'b1, 2'd3, 1'b0, 0, 0); // dirty hit: no wb
    run_req(3'd0, 4'b0000, 4'b1111, 4'b0001, 2'd0, 1'b0, 2'd0, 1'b1, 1, 0); // immediate ack
    run_req(3'd4, 4'b0000, 4'b1110, 4'b0001, 2'd3, 1'b0, 2'd0, 1'b0, 0, 0); // dirty but invalid
`ifdef L2_WAYSEL_MHIT_CHK_EN
    check("mhit_clear", err_mhit_o, 1'b0);
`endif
    run_req(3'd5, 4'b0110, 4'b1111, 4'b0000, 2'd3, 1'b1, 2'd1, 1'b0, 0, 0); // multi-hit
`ifdef L2_WAYSEL_MHIT_CHK_EN
    check("mhit_set", err_mhit_o, 1'b1);
    run_req(3'd6, 4'b0010, 4'b1111, 4'b0000, 2'd0, 1'b1, 2'd1, 1'b0, 0, 0);
    check("mhit_sticky", err_mhit_o, 1'b1);
`endif

    // Reset while a writeback is pending (ack never given).
    req_vld_i     = 1'b1;
    req_index_i   = 3'd4;
    way_hit_i     = 4'b0000;
    way_vld_i     = 4'b1111;
    way_dirty_i   = 4'b0100;
    lru_vtm_way_i = 2'd2;
    @(negedge clk_i);
    req_vld_i = 1'b0;
    @(negedge clk_i);
    check("rw_wb_req", wb_req_o, 1'b1);
    check("rw_wb_way", wb_way_o, 2'd2);
    #2 rst_i = 1'b0;
    #1;
    check("rw_async_wb", wb_req_o, 1'b0);
    check("rw_async_rsp", rsp_vld_o, 1'b0);
    check("rw_async_rdy", req_rdy_o, 1'b1);
`ifdef L2_WAYSEL_MHIT_CHK_EN
    check("rw_mhit_clr", err_mhit_o, 1'b0);
`endif
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("rw_no_upd", lru_update_o, 1'b0);
      check("rw_no_rsp", rsp_vld_o, 1'b0);
      check("rw_idle_rdy", req_rdy_o, 1'b1);
    end
    run_req(3'd2, 4'b0010, 4'b1111, 4'b0000, 2'd0, 1'b1, 2'd1, 1'b0, 0, 0); // recovery

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
